sram_read_arbiter: RTL and testbench

SRAM_READ_ARBITER -- requirements
Module: sram_read_arbiter

---
 rtl/sram_read_arbiter_pkg.sv | 14 +
 rtl/sram_read_arbiter_rr_arbiter2.sv | 45 ++++
 rtl/sram_read_arbiter.sv | 130 +++++++++++++
 tb/tb_sram_read_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_read_arbiter_pkg.sv
// Shared definitions for the SRAM read arbiter: FSM state encoding and
// the default address/data widths used by the CPU-side voice fetchers.
package sram_read_arbiter_pkg;

  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned SRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    CAPTURE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sram_read_arbiter_rr_arbiter2.sv
// Two-way grant logic with a round-robin priority pointer.
// Define SRAM_ARB_FIXED_PRI_EN to drop the pointer: requester 0 always wins ties.
module rr_arbiter2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

`ifdef SRAM_ARB_FIXED_PRI_EN
  logic w_unused_clk_rst;
  assign w_unused_clk_rst = i_clk ^ i_rst_n;

  always_comb begin
    o_gnt = '0;
    if (i_en) begin
      if (i_req[0])      o_gnt = 2'b01;
      else if (i_req[1]) o_gnt = 2'b10;
    end
  end
`else
  logic r_ptr;  // 1: requester 1 wins the next tie

  always_comb begin
    o_gnt = '0;
    if (i_en) begin
      unique case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = r_ptr ? 2'b10 : 2'b01;
        default: o_gnt = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_ptr <= 1'b0;
    else if (|o_gnt)
      r_ptr <= o_gnt[0];
  end
`endif

endmodule

// File: rtl/sram_read_arbiter.sv
// Shares one asynchronous SRAM between two read-only voice fetchers.
// Arbitration mode selected by SRAM_ARB_FIXED_PRI_EN inside rr_arbiter2.
module sram_read_arbiter
  import sram_read_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = SRAM_ADDR_W,
  parameter int unsigned DATA_W      = SRAM_DATA_W,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [ADDR_W-1:0] ADDR1,
  output logic              GNT0,
  output logic              GNT1,
  output logic              VALID0,
  output logic              VALID1,
  output logic [DATA_W-1:0] DATA0,
  output logic [DATA_W-1:0] DATA1,
  output logic [ADDR_W-1:0] SRAM_A,
  input  logic [DATA_W-1:0] SRAM_D,
  output logic              SRAM_CE,
  output logic              SRAM_OE,
  output logic              SRAM_LB,
  output logic              SRAM_UB,
  output logic              SRAM_WE,
  output logic              BUSY
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  arb_state_e        r_state;
  arb_state_e        w_next;
  logic [3:0]        r_wait;
  logic              r_owner;
  logic [ADDR_W-1:0] r_sram_a;
  logic [DATA_W-1:0] r_data0;
  logic [DATA_W-1:0] r_data1;
  logic [1:0]        r_valid;
  logic [1:0]        w_gnt;
  logic              w_arb_en;
  logic              w_busy;

  // Grants are combinational in IDLE; gating with RST_N keeps them low in reset.
  assign w_arb_en = (r_state == IDLE) && RST_N;

  rr_arbiter2 u_arb (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_en    (w_arb_en),
    .i_req   ({REQ1, REQ0}),
    .o_gnt   (w_gnt)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (|w_gnt) w_next = ADDR;
      end
      ADDR: begin
        w_busy = 1'b1;
        if (r_wait == WAIT_LAST) w_next = CAPTURE;
      end
      CAPTURE: begin
        w_busy = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wait   <= '0;
      r_owner  <= 1'b0;
      r_sram_a <= '0;
      r_data0  <= '0;
      r_data1  <= '0;
      r_valid  <= '0;
    end else begin
      r_valid <= '0;
      unique case (r_state)
        IDLE: begin
          if (|w_gnt) begin
            r_wait   <= '0;
            r_owner  <= w_gnt[1];
            r_sram_a <= w_gnt[1] ? ADDR1 : ADDR0;
          end
        end
        ADDR: r_wait <= r_wait + 4'd1;
        CAPTURE: begin
          if (r_owner) begin
            r_data1    <= SRAM_D;
            r_valid[1] <= 1'b1;
          end else begin
            r_data0    <= SRAM_D;
            r_valid[0] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign GNT0    = w_gnt[0];
  assign GNT1    = w_gnt[1];
  assign VALID0  = r_valid[0];
  assign VALID1  = r_valid[1];
  assign DATA0   = r_data0;
  assign DATA1   = r_data1;
  assign SRAM_A  = r_sram_a;
  assign BUSY    = w_busy;
  assign SRAM_CE = 1'b0;
  assign SRAM_OE = 1'b0;
  assign SRAM_LB = 1'b0;
  assign SRAM_UB = 1'b0;
  assign SRAM_WE = 1'b1;

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Directed bench for sram_read_arbiter: transaction table plus hand-written
// sequences for back-to-back, queued-while-busy and mid-transaction reset.
module tb_sram_read_arbiter;

`ifdef SRAM_ARB_FIXED_PRI_EN
  localparam bit FIXED_PRI = 1'b1;
`else
  localparam bit FIXED_PRI = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req0, req1;
  logic [17:0] addr0, addr1;
  logic        gnt0, gnt1, valid0, valid1;
  logic [15:0] data0, data1;
  logic [17:0] sram_a;
  logic [15:0] sram_d;
  logic        sram_ce, sram_oe, sram_lb, sram_ub, sram_we, busy;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [15:0] exp_d0, exp_d1;

  sram_read_arbiter #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(2)) dut (
    .CLK(clk), .RST_N(rst_n),
    .REQ0(req0), .REQ1(req1), .ADDR0(addr0), .ADDR1(addr1),
    .GNT0(gnt0), .GNT1(gnt1), .VALID0(valid0), .VALID1(valid1),
    .DATA0(data0), .DATA1(data1),
    .SRAM_A(sram_a), .SRAM_D(sram_d),
    .SRAM_CE(sram_ce), .SRAM_OE(sram_oe), .SRAM_LB(sram_lb), .SRAM_UB(sram_ub),
    .SRAM_WE(sram_we), .BUSY(busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [15:0] mem_f(input logic [17:0] a);
    if (a == 18'h00010) return 16'h8123;
    return (a[15:0] ^ 16'hC3A5) + {14'd0, a[17:16]};
  endfunction

  assign sram_d = mem_f(sram_a);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] onehot(input int unsigned w);
    return (w == 0) ? 2'b01 : 2'b10;
  endfunction

  // One isolated transaction starting in IDLE; requests drop one cycle after the grant.
  task automatic do_txn(input logic r0, input logic r1, input logic [17:0] a0,
                        input logic [17:0] a1, input int unsigned w);
    logic [17:0] wa;
    wa = (w == 0) ? a0 : a1;
    @(posedge clk); #1;
    req0 = r0; req1 = r1; addr0 = a0; addr1 = a1;
    @(negedge clk);
    chk("txn_gnt", 32'({gnt1, gnt0}), 32'(onehot(w)));
    chk("txn_idle_busy", 32'(busy), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin req0 = 1'b0; req1 = 1'b0; end
      @(negedge clk);
      if (k < 4) chk("txn_busy", 32'(busy), 32'd1);
      if (k == 2) chk("txn_sram_a", 32'(sram_a), 32'(wa));
      chk("txn_valid", 32'({valid1, valid0}), (k == 4) ? 32'(onehot(w)) : 32'd0);
    end
    if (w == 0) exp_d0 = mem_f(wa); else exp_d1 = mem_f(wa);
    chk("txn_gnt_after", 32'({gnt1, gnt0}), 32'd0);
    chk("txn_data0", 32'(data0), 32'(exp_d0));
    chk("txn_data1", 32'(data1), 32'(exp_d1));
  endtask

  typedef struct {
    logic        r0;
    logic        r1;
    logic [17:0] a0;
    logic [17:0] a1;
    int unsigned exp_rr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int unsigned w;
    int unsigned t;
    logic [17:0] sa0, sa1;

    vecs[0] = '{1'b1, 1'b0, 18'h00010, 18'h00000, 0};
    vecs[1] = '{1'b1, 1'b1, 18'h00200, 18'h3FFFF, 1};
    vecs[2] = '{1'b1, 1'b1, 18'h1F00F, 18'h00001, 0};
    vecs[3] = '{1'b0, 1'b1, 18'h00000, 18'h2A5A5, 1};
    vecs[4] = '{1'b1, 1'b0, 18'h00000, 18'h00000, 0};
    vecs[5] = '{1'b1, 1'b1, 18'h12345, 18'h05432, 1};

    exp_d0 = '0; exp_d1 = '0;
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; addr0 = 18'h00010; addr1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
    chk("rst_valid", 32'({valid1, valid0}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data0", 32'(data0), 32'd0);
    chk("rst_data1", 32'(data1), 32'd0);
    chk("rst_sram_a", 32'(sram_a), 32'd0);
    chk("tied_pins", 32'({sram_ce, sram_oe, sram_lb, sram_ub, sram_we}), 32'b00001);
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      w = (vecs[i].r0 && vecs[i].r1 && FIXED_PRI) ? 0 : vecs[i].exp_rr;
      do_txn(vecs[i].r0, vecs[i].r1, vecs[i].a0, vecs[i].a1, w);
    end

    // Both requesters held for ten back-to-back transactions.
    sa0 = 18'h00123; sa1 = 18'h2ABCD;
    for (int cyc = 0; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 0) begin req0 = 1'b1; req1 = 1'b1; addr0 = sa0; addr1 = sa1; end
      if (cyc == 37) begin req0 = 1'b0; req1 = 1'b0; end
      @(negedge clk);
      t = cyc / 4;
      if ((cyc % 4 == 0) && cyc <= 36)
        chk("b2b_gnt", 32'({gnt1, gnt0}), 32'(onehot(FIXED_PRI ? 0 : t % 2)));
      else
        chk("b2b_gnt", 32'({gnt1, gnt0}), 32'd0);
      if ((cyc % 4 == 0) && cyc >= 4) begin
        w = FIXED_PRI ? 0 : (t - 1) % 2;
        chk("b2b_valid", 32'({valid1, valid0}), 32'(onehot(w)));
        if (w == 0) chk("b2b_data0", 32'(data0), 32'(mem_f(sa0)));
        else        chk("b2b_data1", 32'(data1), 32'(mem_f(sa1)));
      end else begin
        chk("b2b_valid", 32'({valid1, valid0}), 32'd0);
      end
    end
    exp_d0 = mem_f(sa0);
    if (!FIXED_PRI) exp_d1 = mem_f(sa1);

    // REQ1 arrives while requester 0 is being served.
    for (int cyc = 0; cyc <= 8; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 0) begin req0 = 1'b1; addr0 = 18'h3FFFF; end
      if (cyc == 1) begin req0 = 1'b0; req1 = 1'b1; addr1 = 18'h00000; end
      if (cyc == 5) req1 = 1'b0;
      @(negedge clk);
      case (cyc)
        0: chk("q_gnt0", 32'({gnt1, gnt0}), 32'b01);
        4: begin
          chk("q_gnt1_at_valid0", 32'({gnt1, gnt0}), 32'b10);
          chk("q_valid0", 32'({valid1, valid0}), 32'b01);
          chk("q_data0", 32'(data0), 32'(mem_f(18'h3FFFF)));
          chk("q_idle", 32'(busy), 32'd0);
        end
        8: begin
          chk("q_valid1", 32'({valid1, valid0}), 32'b10);
          chk("q_data1", 32'(data1), 32'(mem_f(18'h00000)));
        end
        default: begin
          chk("q_no_gnt", 32'({gnt1, gnt0}), 32'd0);
          if (cyc < 4 || (cyc > 4 && cyc < 8)) chk("q_busy", 32'(busy), 32'd1);
        end
      endcase
    end
    exp_d0 = mem_f(18'h3FFFF); exp_d1 = mem_f(18'h00000);

    // Reset pulse while in ADDR aborts the read.
    @(posedge clk); #1;
    req0 = 1'b1; addr0 = 18'h00777;
    @(negedge clk);
    chk("r_gnt0", 32'({gnt1, gnt0}), 32'b01);
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    chk("r_in_addr", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("r_busy_now", 32'(busy), 32'd0);
    chk("r_data0_clr", 32'(data0), 32'd0);
    chk("r_data1_clr", 32'(data1), 32'd0);
    chk("r_sram_a_clr", 32'(sram_a), 32'd0);
    exp_d0 = '0; exp_d1 = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      chk("r_no_valid", 32'({valid1, valid0}), 32'd0);
    end
    do_txn(1'b1, 1'b0, 18'h00155, 18'h00000, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
